// File: rtl/mmm_controller.sv
// mmm_controller: sequencer for the matrix-multiply unit beside the pipelined processor.
//
// Computes C = A x B for square K x K signed matrices stored row-major at word 0 of
// data banks 1 (A), 2 (B) and 3 (C). It performs one multiply-accumulate per cycle.
// Each C element takes K RUN cycles, then one DRAIN cycle, then one WRITE cycle.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   K_in, start_mmm   matrix dimension, sampled on the start pulse
//   wait_mmm_finish   processor is waiting; gates stall
//   mata_data/matb_data   bank-1/bank-2 read data (1-cycle read latency)
//   rdaddr_mem1/rdaddr_mem2   A/B read word addresses
//   outmat_data, wraddr_mem3, outmat_byte_wren   bank-3 write port
//   stall, busy, done, err   pipeline freeze, activity, completion pulse, sticky reject
//
// Build option: define MMM_SATURATE_EN to accumulate at full product width and clamp
// acc to the signed OUTW range after each step. The default build truncates the
// product to OUTW bits and wraps the sum. Cycle timing is the same in both builds.

module mmm_controller #(
  parameter int unsigned QUARTERSIZE = 256,
  parameter int unsigned INW         = 32,
  parameter int unsigned OUTW        = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [31:0]                     K_in,
  input  logic                            start_mmm,
  input  logic                            wait_mmm_finish,
  input  logic [INW-1:0]                  mata_data,
  input  logic [INW-1:0]                  matb_data,
  output logic [$clog2(QUARTERSIZE)-1:0]  rdaddr_mem1,
  output logic [$clog2(QUARTERSIZE)-1:0]  rdaddr_mem2,
  output logic [OUTW-1:0]                 outmat_data,
  output logic [$clog2(QUARTERSIZE)-1:0]  wraddr_mem3,
  output logic [3:0]                      outmat_byte_wren,
  output logic                            stall,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned QUARTER_BITS = $clog2(QUARTERSIZE);
  localparam logic [QUARTER_BITS-1:0] OneQ = QUARTER_BITS'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StWrite} state_e;

  state_e                  state_q, state_d;
  // A valid K never exceeds sqrt(QUARTERSIZE), so it fits in a bank address.
  logic [QUARTER_BITS-1:0] k_dim_q, k_dim_d;
  logic [QUARTER_BITS-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [QUARTER_BITS-1:0] a_row_q, a_row_d;  // i*K
  logic [QUARTER_BITS-1:0] a_ptr_q, a_ptr_d;  // i*K+k
  logic [QUARTER_BITS-1:0] b_ptr_q, b_ptr_d;  // k*K+j
  logic [QUARTER_BITS-1:0] c_ptr_q, c_ptr_d;  // i*K+j
  logic [QUARTER_BITS-1:0] rd1_q, rd1_d, rd2_q, rd2_d;  // last issued read addresses
  logic [OUTW-1:0]         acc_q, acc_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [63:0]             k_sq;
  logic                    k_ok;
  logic [QUARTER_BITS-1:0] k_max;
  logic [OUTW-1:0]         acc_sum;

  // Full-width square so a huge K_in cannot alias into a small legal value.
  assign k_sq  = 64'(K_in) * 64'(K_in);
  assign k_ok  = (K_in != 32'd0) && (k_sq <= 64'(QUARTERSIZE));
  assign k_max = k_dim_q - OneQ;

`ifdef MMM_SATURATE_EN
  localparam int unsigned SW = 2 * INW + 1;
  localparam logic signed [SW-1:0] SatMax = $signed({{(SW - OUTW + 1){1'b0}}, {(OUTW - 1){1'b1}}});
  localparam logic signed [SW-1:0] SatMin = $signed({{(SW - OUTW + 1){1'b1}}, {(OUTW - 1){1'b0}}});

  logic signed [2*INW-1:0] prod_full;
  logic signed [SW-1:0]    sum_wide;

  assign prod_full = $signed(mata_data) * $signed(matb_data);
  assign sum_wide  = SW'($signed(acc_q)) + SW'(prod_full);

  always_comb begin
    acc_sum = sum_wide[OUTW-1:0];
    if (sum_wide > SatMax) begin
      acc_sum = SatMax[OUTW-1:0];
    end else if (sum_wide < SatMin) begin
      acc_sum = SatMin[OUTW-1:0];
    end
  end
`else
  logic [OUTW-1:0] prod_trunc;

  // Low OUTW bits of the signed product; the sum wraps naturally.
  assign prod_trunc = $signed(mata_data) * $signed(matb_data);
  assign acc_sum    = acc_q + prod_trunc;
`endif

  always_comb begin
    state_d = state_q;
    k_dim_d = k_dim_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_row_d = a_row_q;
    a_ptr_d = a_ptr_q;
    b_ptr_d = b_ptr_q;
    c_ptr_d = c_ptr_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    acc_d   = acc_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    // Read data arrives one cycle after each RUN issue.
    if (valid_q) begin
      acc_d = acc_sum;
    end

    unique case (state_q)
      StIdle: begin
        if (start_mmm) begin
          if (k_ok) begin
            k_dim_d = K_in[QUARTER_BITS-1:0];
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            a_row_d = '0;
            a_ptr_d = '0;
            b_ptr_d = '0;
            c_ptr_d = '0;
            acc_d   = '0;
            err_d   = 1'b0;
            state_d = StRun;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        rd1_d   = a_ptr_q;
        rd2_d   = b_ptr_q;
        valid_d = 1'b1;
        a_ptr_d = a_ptr_q + OneQ;
        // Overshoots after the last issue; reloaded in WRITE before reuse.
        b_ptr_d = b_ptr_q + k_dim_q;
        k_d     = k_q + OneQ;
        if (k_q == k_max) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StWrite;
      end
      StWrite: begin
        acc_d   = '0;
        k_d     = '0;
        c_ptr_d = c_ptr_q + OneQ;
        if (j_q != k_max) begin
          j_d     = j_q + OneQ;
          a_ptr_d = a_row_q;
          b_ptr_d = j_q + OneQ;
          state_d = StRun;
        end else if (i_q != k_max) begin
          i_d     = i_q + OneQ;
          j_d     = '0;
          a_row_d = a_row_q + k_dim_q;
          a_ptr_d = a_row_q + k_dim_q;
          b_ptr_d = '0;
          state_d = StRun;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      k_dim_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_row_q <= '0;
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      c_ptr_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_dim_q <= k_dim_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_row_q <= a_row_d;
      a_ptr_q <= a_ptr_d;
      b_ptr_q <= b_ptr_d;
      c_ptr_q <= c_ptr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  logic wr_active;

  always_comb begin
    wr_active        = (state_q == StWrite);
    // Live pointer during RUN, otherwise hold the last issued address.
    rdaddr_mem1      = (state_q == StRun) ? a_ptr_q : rd1_q;
    rdaddr_mem2      = (state_q == StRun) ? b_ptr_q : rd2_q;
    outmat_data      = wr_active ? acc_q : '0;
    wraddr_mem3      = wr_active ? c_ptr_q : '0;
    outmat_byte_wren = wr_active ? 4'hF : 4'h0;
    busy             = (state_q != StIdle);
    stall            = wait_mmm_finish & busy;
    done             = done_q;
    err              = err_q;
  end

endmodule

// File: tb/tb_mmm_controller.sv
module tb_mmm_controller;

  logic        clk;
  logic        reset;
  logic [31:0] K_in;
  logic        start_mmm;
  logic        wait_mmm_finish;
  logic [31:0] mata_data;
  logic [31:0] matb_data;
  logic [7:0]  rdaddr_mem1;
  logic [7:0]  rdaddr_mem2;
  logic [31:0] outmat_data;
  logic [7:0]  wraddr_mem3;
  logic [3:0]  outmat_byte_wren;
  logic        stall;
  logic        busy;
  logic        done;
  logic        err;

  mmm_controller #(
    .QUARTERSIZE(256),
    .INW        (32),
    .OUTW       (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .K_in            (K_in),
    .start_mmm       (start_mmm),
    .wait_mmm_finish (wait_mmm_finish),
    .mata_data       (mata_data),
    .matb_data       (matb_data),
    .rdaddr_mem1     (rdaddr_mem1),
    .rdaddr_mem2     (rdaddr_mem2),
    .outmat_data     (outmat_data),
    .wraddr_mem3     (wraddr_mem3),
    .outmat_byte_wren(outmat_byte_wren),
    .stall           (stall),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  typedef struct {
    int cyc;
    int err;
  } dn_t;

  int  n_checks = 0;
  int  n_bad    = 0;
  int  cyc      = 0;
  int  mem_a[256];
  int  mem_b[256];
  wr_t wr_q[$];
  dn_t dn_q[$];
  wr_t we;
  dn_t de;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Banks 1 and 2: one-cycle read latency.
  always @(posedge clk) begin
    mata_data <= mem_a[rdaddr_mem1];
    matb_data <= mem_b[rdaddr_mem2];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mac(input int acc, input int a, input int b);
`ifdef MMM_SATURATE_EN
    longint s;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    s  = longint'(acc) + longint'(a) * longint'(b);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return int'(s);
`else
    return acc + a * b;
`endif
  endfunction

  // Push the expected bank-3 writes and done pulse for a start issued in cycle s.
  task automatic push_run(input int kk, input int s);
    int acc;
    int n;
    if (kk == 0 || kk * kk > 256) begin
      dn_q.push_back('{cyc: s + 1, err: 1});
    end else begin
      n = 0;
      for (int i = 0; i < kk; i++) begin
        for (int j = 0; j < kk; j++) begin
          acc = 0;
          for (int k = 0; k < kk; k++) acc = mac(acc, mem_a[i*kk+k], mem_b[k*kk+j]);
          wr_q.push_back('{addr: i * kk + j, data: acc, cyc: s + (n + 1) * (kk + 2)});
          n++;
        end
      end
      dn_q.push_back('{cyc: s + kk * kk * (kk + 2) + 1, err: 0});
    end
  endtask

  task automatic start_run(input int kk);
    K_in      = kk;
    start_mmm = 1'b1;
    push_run(kk, cyc);
    tick();
    start_mmm = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || dn_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (wr_q.size() != 0 || dn_q.size() != 0) begin
      check("drain_timeout", 32'(wr_q.size() + dn_q.size()), 32'd0);
      wr_q.delete();
      dn_q.delete();
    end
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd1"}, 32'(rdaddr_mem1), 32'd0);
    check({tag, "_rd2"}, 32'(rdaddr_mem2), 32'd0);
    check({tag, "_wdata"}, outmat_data, 32'd0);
    check({tag, "_waddr"}, 32'(wraddr_mem3), 32'd0);
    check({tag, "_wren"}, 32'(outmat_byte_wren), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Scoreboard: every bank-3 write and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (outmat_byte_wren != 4'h0) begin
      if (wr_q.size() == 0) begin
        check("unexp_write", 32'(outmat_byte_wren), 32'd0);
      end else begin
        we = wr_q.pop_front();
        check("wr_wren", 32'(outmat_byte_wren), 32'hF);
        check("wr_addr", 32'(wraddr_mem3), we.addr);
        check("wr_data", outmat_data, we.data);
        check("wr_cycle", cyc, we.cyc);
      end
    end
    if (done) begin
      if (dn_q.size() == 0) begin
        check("unexp_done", 32'(done), 32'd0);
      end else begin
        de = dn_q.pop_front();
        check("done_cycle", cyc, de.cyc);
        check("done_err", 32'(err), de.err);
        check("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset           = 1'b1;
    start_mmm       = 1'b0;
    K_in            = '0;
    wait_mmm_finish = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 0;
      mem_b[i] = 0;
    end
    repeat (3) tick();
    reset           = 1'b0;
    wait_mmm_finish = 1'b1;
    tick();
    check_all_zero("reset");
    wait_mmm_finish = 1'b0;

    // 2x2 product with address sequence spot checks.
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
    mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
    start_run(2);
    check("run_busy", 32'(busy), 32'd1);
    check("run1_rd1", 32'(rdaddr_mem1), 32'd0);
    check("run1_rd2", 32'(rdaddr_mem2), 32'd0);
    tick();
    check("run2_rd1", 32'(rdaddr_mem1), 32'd1);
    check("run2_rd2", 32'(rdaddr_mem2), 32'd2);
    tick();
    check("drain_rd1_hold", 32'(rdaddr_mem1), 32'd1);
    check("drain_rd2_hold", 32'(rdaddr_mem2), 32'd2);
    check("drain_wren", 32'(outmat_byte_wren), 32'd0);
    wait_idle(100);

    // Stall gating on a K=3 run.
    for (int i = 0; i < 9; i++) begin
      mem_a[i] = int'($urandom_range(0, 200)) - 100;
      mem_b[i] = int'($urandom_range(0, 200)) - 100;
    end
    start_run(3);
    tick();
    wait_mmm_finish = 1'b1;
    for (int c = 2; c <= 45; c++) begin
      #1;
      check("stall_high", 32'(stall), 32'd1);
      tick();
    end
    check("stall_low_end", 32'(stall), 32'd0);
    check("stall_end_busy", 32'(busy), 32'd0);
    check("stall_end_done", 32'(done), 32'd1);
    wait_mmm_finish = 1'b0;
    wait_idle(100);

    // Rejected starts, then a valid K=1 clears err.
    start_run(0);
    check("k0_err", 32'(err), 32'd1);
    check("k0_busy", 32'(busy), 32'd0);
    wait_idle(20);
    start_run(17);
    check("k17_err", 32'(err), 32'd1);
    wait_idle(20);
    repeat (3) tick();
    check("err_sticky", 32'(err), 32'd1);
    mem_a[0] = 7;
    mem_b[0] = -3;
    start_run(1);
    check("k1_err_clear", 32'(err), 32'd0);
    wait_idle(20);

    // Overflow behaviour of a single product.
    mem_a[0] = 32'h7FFF_FFFF;
    mem_b[0] = 2;
    start_run(1);
    wait_idle(20);

    // Reset in cycle 6 of a K=2 run.
    mem_a[0] = -9; mem_a[1] = 4; mem_a[2] = 11; mem_a[3] = -2;
    mem_b[0] = 3;  mem_b[1] = -5; mem_b[2] = 6; mem_b[3] = 10;
    start_run(2);
    repeat (5) tick();
    reset = 1'b1;
    wr_q.delete();
    dn_q.delete();
    tick();
    reset = 1'b0;
    check_all_zero("midreset");
    repeat (12) tick();
    start_run(2);
    wait_idle(100);

    // Reset beats a simultaneous start.
    reset     = 1'b1;
    start_mmm = 1'b1;
    K_in      = 2;
    tick();
    reset     = 1'b0;
    start_mmm = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    repeat (10) tick();

    // Second start during RUN is ignored.
    mem_a[0] = 2; mem_a[1] = -1; mem_a[2] = 5; mem_a[3] = 3;
    mem_b[0] = 4; mem_b[1] = 7;  mem_b[2] = -6; mem_b[3] = 1;
    start_run(2);
    tick();
    K_in      = 3;
    start_mmm = 1'b1;
    tick();
    start_mmm = 1'b0;
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
